fifo_stream_reader: RTL and testbench

Read-side adapter that drains the team's 8-bit circular-buffer FIFO and presents its contents as a valid/ready stream. It drives the FIFO's `rd` strobe, accounts for the FIFO's one-cycle registered read latency, and holds prefetched words in a 2-entry output buffer so a continuously ready sink receives one word per cycle. It sits between the FIFO and any stream consumer, such as a serializer or packet builder.

---
 rtl/fifo_pkg.sv | 5 +
 rtl/stream_buf2.sv | 44 ++++
 rtl/fifo_stream_reader.sv | 61 ++++++
 tb/tb_fifo_stream_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the 8-bit circular-buffer FIFO and its read-side adapters.
package fifo_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int BUF_DEPTH   = 2;
endpackage

// File: rtl/stream_buf2.sv
// Two-entry output store with head/tail pointers and occupancy; clr empties it.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] store [BUF_DEPTH];
  logic              head;
  logic              tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store[0] <= '0;
      store[1] <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      occ      <= 2'd0;
    end else if (clr) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push) begin
        store[tail] <= push_data;
        tail        <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = store[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the registered-read FIFO into a valid/ready stream through a 2-entry prefetch buffer.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic [1:0] occ;
  logic       pend;
  logic       pop;
  logic       push;
  logic [2:0] load;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign push    = pend && !flush;

  // A pop always has occ >= 1, so load cannot underflow.
  assign load    = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
  assign fifo_rd = rst_n && !flush && !fifo_empty && (load <= 3'd1);

  stream_buf2 #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (push),
    .push_data(fifo_dout),
    .pop      (pop),
    .occ      (occ),
    .head_data(m_data)
  );

  // Read issued this cycle returns on fifo_dout next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      pend     <= fifo_rd;
      xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, pop};
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, occ} + {2'b0, pend}) <= 3'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural registered-read FIFO.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       flush;
  logic [15:0] xfer_cnt;

  logic       fifo_rd4;
  logic       m_valid4;
  logic [7:0] m_data4;
  logic [3:0] xfer_cnt4;

  fifo_stream_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .flush(flush), .xfer_cnt(xfer_cnt)
  );

  fifo_stream_reader #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd4), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .flush(flush), .xfer_cnt(xfer_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fmem [0:63];
  int wp = 0;
  int rp = 0;
  logic fifo_clr;

  assign fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (fifo_clr) rp <= wp;
    else if (fifo_rd && !fifo_empty) begin
      fifo_dout <= fmem[rp[5:0]];
      rp        <= rp + 1;
    end
  end

  logic [7:0] got [$];
  int rd_cnt = 0;
  int bad_rd = 0;
  int inflight = 0;
  int max_if = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 0;
    end else begin
      if (m_valid && m_ready) got.push_back(m_data);
      if (fifo_rd) rd_cnt <= rd_cnt + 1;
      if (fifo_rd && fifo_empty) bad_rd <= bad_rd + 1;
      inflight <= flush ? 0 : inflight + int'(fifo_rd) - int'(m_valid && m_ready);
      if (inflight > max_if) max_if <= inflight;
    end
  end

  int ncmp = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    fmem[wp[5:0]] = v;
    wp = wp + 1;
  endtask

  int snap;
  int g0;

  initial begin
    rst_n = 1'b1; m_ready = 1'b0; flush = 1'b0; fifo_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_cnt", xfer_cnt, 0);
    check("rst_rd", fifo_rd, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_valid", m_valid, 0);
    check("idle_rd", fifo_rd, 0);

    // Streaming 0x11..0x18 with a continuously ready sink
    m_ready = 1'b1;
    snap = rd_cnt;
    g0 = got.size();
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    #1;
    check("str_rd_issue", fifo_rd, 1);
    step();
    check("str_lat_valid", m_valid, 0);
    step();
    check("str_first_valid", m_valid, 1);
    check("str_first_data", m_data, 8'h11);
    for (int i = 1; i < 8; i++) begin
      step();
      check("str_valid", m_valid, 1);
      check("str_data", m_data, 8'h11 + 8'(i));
    end
    step(); step();
    check("str_cnt", xfer_cnt, 8);
    check("str_cnt4", xfer_cnt4, 8);
    check("str_drained", m_valid, 0);
    check("str_reads", rd_cnt - snap, 8);
    check("str_rd_empty", bad_rd, 0);
    check("str_got_n", got.size() - g0, 8);

    // Backpressure: sink stalled for 10 cycles
    m_ready = 1'b0;
    snap = rd_cnt;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i >= 2) begin
        check("bp_valid", m_valid, 1);
        check("bp_hold", m_data, 8'hA0);
      end
    end
    check("bp_reads", rd_cnt - snap, 2);
    check("bp_rd_low", fifo_rd, 0);
    g0 = got.size();
    m_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      step();
      check("bp_b2b_valid", m_valid, 1);
      check("bp_b2b_data", m_data, 8'hA0 + 8'(i));
    end
    step(); step(); step();
    check("bp_got_n", got.size() - g0, 6);
    for (int i = 0; i < 6; i++) check("bp_order", got[g0 + i], 8'hA0 + 8'(i));

    // Alternating ready over 16 words
    m_ready = 1'b0;
    g0 = got.size();
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    for (int i = 0; i < 48; i++) begin
      step();
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    step(); step(); step();
    check("alt_got_n", got.size() - g0, 16);
    for (int i = 0; i < 16; i++) check("alt_order", got[g0 + i], 8'h30 + 8'(i));
    check("alt_inflight_max", 32'(max_if <= 2), 1);

    // Flush with one word buffered and one read in flight
    m_ready = 1'b0;
    g0 = got.size();
    snap = xfer_cnt;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    step(); step();
    check("fl_pre_valid", m_valid, 1);
    check("fl_pre_data", m_data, 8'h60);
    flush = 1'b1;
    #1;
    check("fl_rd_blocked", fifo_rd, 0);
    step();
    flush = 1'b0;
    #1;
    check("fl_valid_low", m_valid, 0);
    check("fl_resume_rd", fifo_rd, 1);
    m_ready = 1'b1;
    step();
    step();
    check("fl_next_valid", m_valid, 1);
    check("fl_next_data", m_data, 8'h62);
    step(); step(); step(); step();
    check("fl_got_n", got.size() - g0, 3);
    check("fl_got_first", got[g0], 8'h62);
    check("fl_got_last", got[g0 + 2], 8'h64);
    check("fl_cnt", xfer_cnt - snap, 3);

    // Reset in mid-stream
    for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("mrst_valid", m_valid, 0);
    check("mrst_data", m_data, 0);
    check("mrst_cnt", xfer_cnt, 0);
    check("mrst_cnt4", xfer_cnt4, 0);
    check("mrst_rd", fifo_rd, 0);
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    step();
    rst_n = 1'b1;
    push(8'h5A);
    step(); step();
    check("mrst_5a_valid", m_valid, 1);
    check("mrst_5a_data", m_data, 8'h5A);
    step();
    check("mrst_5a_cnt", xfer_cnt, 1);
    check("mrst_5a_empty", m_valid, 0);

    // 16 more transfers: 17 since reset wraps the 4-bit counter to 1
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    for (int i = 0; i < 20; i++) step();
    check("wrap_cnt16", xfer_cnt, 17);
    check("wrap_cnt4", xfer_cnt4, 1);
    check("wrap_last", got[got.size() - 1], 8'h8F);
    check("wrap_rd_empty", bad_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
